// File: rtl/adc_ad7476_seq.sv
// AD7476A-style serial ADC sequencer: sample-rate timer, 16-bit frame capture,
// and a first-word-fall-through FIFO of 12-bit samples.
module adc_ad7476_seq #(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int QUIET_CYC     = 4,
    parameter int FIFO_AW       = 3
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               enable_i,
    input  logic               single_i,
    output logic               cs_n_o,
    output logic               sck_o,
    input  logic               miso_i,
    output logic [11:0]        sample_o,
    input  logic               sample_rd_i,
    output logic               fifo_empty_o,
    output logic [FIFO_AW:0]   fifo_cnt_o,
    output logic               busy_o,
    output logic               overflow_o,
    output logic               overrun_o,
    output logic               frame_err_o,
    input  logic               err_clr_i
);

    localparam int DEPTH    = 1 << FIFO_AW;
    localparam int HOLD_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
    localparam int CW       = $clog2(HOLD_MAX + 1);
    localparam int TW       = $clog2(SAMPLE_PERIOD);

    localparam logic [CW-1:0]      DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]      QUIET_LAST = CW'(QUIET_CYC - 1);
    localparam logic [TW-1:0]      TICK_AT    = TW'(SAMPLE_PERIOD - 1);
    localparam logic [FIFO_AW:0]   FULL_CNT   = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SCK_LO,
        S_SCK_HI,
        S_QUIET
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_hold;
    logic [4:0]         r_bits;
    logic [15:0]        r_shreg;
    logic [TW-1:0]      r_timer;
    logic               r_pending;
    logic               r_overrun;
    logic               r_overflow;
    logic               r_frame_err;
    logic [11:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wp;
    logic [FIFO_AW-1:0] r_rp;
    logic [FIFO_AW:0]   r_cnt;

    logic w_tick;
    logic w_launch;
    logic w_div_done;
    logic w_push;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_wr;
    logic w_drop;
    logic w_ferr;

    assign w_tick     = enable_i && (r_timer == TICK_AT);
    assign w_launch   = (r_state == S_IDLE) &&
                        (r_pending || (single_i && !enable_i));
    assign w_div_done = (r_hold == DIV_LAST);
    assign w_push     = (r_state == S_SCK_HI) && w_div_done &&
                        (r_bits == 5'd16);
    assign w_full     = (r_cnt == FULL_CNT);
    assign w_empty    = (r_cnt == '0);
    assign w_pop      = sample_rd_i && !w_empty;
    // A pop frees the slot the same edge, so a full FIFO still accepts.
    assign w_wr       = w_push && (!w_full || w_pop);
    assign w_drop     = w_push && w_full && !w_pop;
    assign w_ferr     = w_push && (r_shreg[15:12] != 4'h0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_timer   <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (!enable_i) begin
                r_timer   <= '0;
                r_pending <= 1'b0;
            end else begin
                r_timer <= w_tick ? '0 : r_timer + 1'b1;
                if (w_tick)
                    r_pending <= 1'b1;
                else if (w_launch)
                    r_pending <= 1'b0;
            end
            if (w_tick && r_pending)
                r_overrun <= 1'b1;
            else if (err_clr_i)
                r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_bits  <= '0;
            r_shreg <= '0;
            cs_n_o  <= 1'b1;
            sck_o   <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        cs_n_o  <= 1'b0;
                        r_hold  <= '0;
                        r_bits  <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_div_done) begin
                        r_hold  <= '0;
                        sck_o   <= 1'b0;
                        r_shreg <= {r_shreg[14:0], miso_i};
                        r_bits  <= r_bits + 1'b1;
                        r_state <= S_SCK_LO;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_SCK_LO: begin
                    if (w_div_done) begin
                        r_hold  <= '0;
                        sck_o   <= 1'b1;
                        r_state <= S_SCK_HI;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_SCK_HI: begin
                    if (w_div_done) begin
                        r_hold <= '0;
                        if (r_bits == 5'd16) begin
                            cs_n_o  <= 1'b1;
                            r_state <= S_QUIET;
                        end else begin
                            sck_o   <= 1'b0;
                            r_shreg <= {r_shreg[14:0], miso_i};
                            r_bits  <= r_bits + 1'b1;
                            r_state <= S_SCK_LO;
                        end
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_QUIET: begin
                    if (r_hold == QUIET_LAST) begin
                        r_hold  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_drop)
                r_overflow <= 1'b1;
            else if (err_clr_i)
                r_overflow <= 1'b0;
            if (w_ferr)
                r_frame_err <= 1'b1;
            else if (err_clr_i)
                r_frame_err <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            if (w_wr) begin
                r_mem[r_wp] <= r_shreg[11:0];
                r_wp        <= r_wp + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign sample_o     = r_mem[r_rp];
    assign fifo_empty_o = w_empty;
    assign fifo_cnt_o   = r_cnt;
    assign busy_o       = (r_state != S_IDLE);
    assign overflow_o   = r_overflow;
    assign overrun_o    = r_overrun;
    assign frame_err_o  = r_frame_err;

endmodule

// File: tb/tb_adc_ad7476_seq.sv
// Bench for adc_ad7476_seq: behavioural ADC, queue-based FIFO/flag model,
// directed scenarios plus a randomized run; a second instance covers overrun.
module tb_adc_ad7476_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic single = 1'b0;
    logic miso = 1'b0;
    logic rd = 1'b0;
    logic clr = 1'b0;
    logic cs_n, sck, fifo_empty, busy, ovf, ovr, ferr;
    logic [11:0] sample;
    logic [3:0] cnt;

    logic en40 = 1'b0;
    logic clr40 = 1'b0;
    logic cs40, sck40, empty40, busy40, ovf40, ovr40, ferr40;
    logic [11:0] sample40;
    logic [3:0] cnt40;

    int n_chk = 0;
    int n_fail = 0;
    int falls = 0;
    int lowcnt = 0;
    int frames_done = 0;
    int cyc = 0;
    logic [15:0] adc_word = '0;
    logic [15:0] adc_q[$];
    logic [11:0] exp_q[$];
    bit exp_ovf = 1'b0;
    bit exp_ferr = 1'b0;
    int l40_q[$];

    localparam int FRAME_GAP = 33 * 2 + 4 + 1;

    adc_ad7476_seq #(
        .CLK_DIV(2), .SAMPLE_PERIOD(100), .QUIET_CYC(4), .FIFO_AW(3)
    ) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable),
        .single_i(single), .cs_n_o(cs_n), .sck_o(sck),
        .miso_i(miso), .sample_o(sample), .sample_rd_i(rd),
        .fifo_empty_o(fifo_empty), .fifo_cnt_o(cnt), .busy_o(busy),
        .overflow_o(ovf), .overrun_o(ovr), .frame_err_o(ferr),
        .err_clr_i(clr)
    );

    adc_ad7476_seq #(
        .CLK_DIV(2), .SAMPLE_PERIOD(40), .QUIET_CYC(4), .FIFO_AW(3)
    ) u_dut40 (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en40),
        .single_i(1'b0), .cs_n_o(cs40), .sck_o(sck40),
        .miso_i(1'b0), .sample_o(sample40), .sample_rd_i(1'b0),
        .fifo_empty_o(empty40), .fifo_cnt_o(cnt40), .busy_o(busy40),
        .overflow_o(ovf40), .overrun_o(ovr40), .frame_err_o(ferr40),
        .err_clr_i(clr40)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp_v);
        n_chk++;
        if (got != exp_v) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
        end
    endtask

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 3) != 0)
            w[15:12] = 4'h0;
        return w;
    endfunction

    // ADC side: first bit on cs fall, next bit after each sck fall.
    always @(negedge cs_n) begin
        falls = 0;
        lowcnt = 0;
        adc_word = (adc_q.size() > 0) ? adc_q.pop_front() : rnd_word();
        miso = adc_word[15];
    end

    always @(negedge sck) begin
        if (!cs_n) begin
            falls++;
            if (falls < 16)
                miso = adc_word[15 - falls];
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (!cs_n)
            lowcnt++;
    end

    // Frame end: reference FIFO and sticky flags.
    always @(posedge cs_n) begin
        if (rst_n) begin
            chk("cs_low_clks", lowcnt, 66);
            chk("sck_falls", falls, 16);
            frames_done++;
            if (exp_q.size() == 8)
                exp_ovf = 1'b1;
            else
                exp_q.push_back(adc_word[11:0]);
            if (adc_word[15:12] != 4'h0)
                exp_ferr = 1'b1;
        end
    end

    always @(negedge cs40)
        l40_q.push_back(cyc);

    task automatic pop_chk(input string tag);
        chk({tag, "_empty"}, int'(fifo_empty), int'(exp_q.size() == 0));
        if (exp_q.size() > 0)
            chk({tag, "_head"}, int'(sample), int'(exp_q[0]));
        rd = 1'b1;
        @(posedge clk);
        if (exp_q.size() > 0)
            exp_q.delete(0);
        @(negedge clk);
        rd = 1'b0;
        chk({tag, "_cnt"}, int'(cnt), exp_q.size());
        chk({tag, "_ovf"}, int'(ovf), int'(exp_ovf));
        chk({tag, "_ferr"}, int'(ferr), int'(exp_ferr));
    endtask

    task automatic single_shot();
        @(negedge clk);
        single = 1'b1;
        @(negedge clk);
        single = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frames_timeout", frames_done, n);
    endtask

    task automatic clear_err();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        exp_ovf = 1'b0;
        exp_ferr = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int k;
        int base;
        int n40;

        repeat (3) @(negedge clk);
        chk("rst_cs_n", int'(cs_n), 1);
        chk("rst_sck", int'(sck), 1);
        chk("rst_sample", int'(sample), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_empty", int'(fifo_empty), 1);
        chk("rst_flags", int'({ovf, ovr, ferr}), 0);
        chk("rst_busy", int'(busy), 0);

        // single conversion
        adc_q.push_back(16'h0AA5);
        single_shot();
        chk("t1_busy", int'(busy), 1);
        wait_idle(200);
        chk("t1_sample", int'(sample), 12'hAA5);
        chk("t1_cnt", int'(cnt), 1);
        chk("t1_ferr", int'(ferr), 0);
        pop_chk("t1");

        // timed launches, fill then overflow
        for (int n = 0; n < 9; n++)
            adc_q.push_back(16'h0AA5 + 16'(n));
        base = frames_done;
        @(negedge clk);
        enable = 1'b1;
        wait_frames(base + 9, 2000);
        enable = 1'b0;
        wait_idle(200);
        chk("t2_cnt", int'(cnt), 8);
        chk("t2_ovf", int'(ovf), 1);
        chk("t2_head", int'(sample), 12'hAA5);
        clear_err();
        chk("t2_ovf_clr", int'(ovf), 0);

        // pop on the push edge while full
        adc_q.push_back(16'h0BBB);
        single_shot();
        repeat (65) @(negedge clk);
        pop_chk("t3");
        chk("t3_cs_up", int'(cs_n), 1);
        chk("t3_cnt", int'(cnt), 8);
        chk("t3_ovf", int'(ovf), 0);
        chk("t3_head", int'(sample), 12'hAA6);
        wait_idle(200);
        for (int n = 0; n < 8; n++)
            pop_chk("t3_drain");

        // frame error
        adc_q.push_back(16'h8123);
        single_shot();
        wait_idle(200);
        chk("t5_sample", int'(sample), 12'h123);
        chk("t5_ferr", int'(ferr), 1);
        clear_err();
        chk("t5_ferr_clr", int'(ferr), 0);
        pop_chk("t5");

        // overrun on the fast-period instance
        @(negedge clk);
        en40 = 1'b1;
        k = 0;
        while (l40_q.size() < 5 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        en40 = 1'b0;
        chk("t4_launches", l40_q.size(), 5);
        for (int i = 1; i < 5; i++)
            if (i < l40_q.size())
                chk("t4_gap", l40_q[i] - l40_q[i-1], FRAME_GAP);
        n40 = l40_q.size();
        repeat (200) @(negedge clk);
        chk("t4_no_extra", l40_q.size(), n40);
        chk("t4_busy", int'(busy40), 0);
        chk("t4_ovr", int'(ovr40), 1);
        chk("t4_cnt", int'(cnt40), 5);
        chk("t4_data", int'({sample40, empty40, ovf40, ferr40}), 0);
        @(negedge clk);
        clr40 = 1'b1;
        @(negedge clk);
        clr40 = 1'b0;
        chk("t4_ovr_clr", int'(ovr40), 0);

        // reset mid-frame
        adc_q.push_back(rnd_word());
        single_shot();
        k = 0;
        while (falls < 7 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("t6_reach_bit7", int'(falls >= 7), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_cs_n", int'(cs_n), 1);
        chk("t6_sck", int'(sck), 1);
        chk("t6_empty", int'(fifo_empty), 1);
        chk("t6_busy", int'(busy), 0);
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_ferr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        adc_q.push_back(16'h0C3A);
        single_shot();
        wait_idle(200);
        chk("t6_sample", int'(sample), 12'hC3A);
        pop_chk("t6");

        // randomized run with random reads
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, (i < 1500) ? 249 : 7) == 0)
                pop_chk("rnd");
            else
                @(negedge clk);
        end
        enable = 1'b0;
        wait_idle(200);
        chk("rnd_cnt", int'(cnt), exp_q.size());
        chk("rnd_ovf", int'(ovf), int'(exp_ovf));
        chk("rnd_ferr", int'(ferr), int'(exp_ferr));
        k = 0;
        while (exp_q.size() > 0 && k < 20) begin
            pop_chk("rnd_drain");
            k++;
        end
        chk("rnd_final_empty", int'(fifo_empty), 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
